// File: rtl/delay_timer_bank.sv
// -----------------------------------------------------------------------------
// delay_timer_bank
//
// Bank of independent millisecond delay timers for the maze game loop
// (movement debounce, animation step pacing, periodic game ticks). Each
// channel is armed with a millisecond count and pulses `expired` when the
// delay has elapsed. Channels can be one-shot or auto-reloading, and can
// be cancelled at any time.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   set       in   [CHANNELS]            per-channel arm request
//   ms        in   [CHANNELS*MS_WIDTH]   per-channel delay, channel i at [i*MS_WIDTH +: MS_WIDTH]
//   periodic  in   [CHANNELS]            mode latched on arm, 1 = auto-reload
//   cancel    in   [CHANNELS]            per-channel abort
//   free      out  [CHANNELS]            channel idle and ready to arm
//   expired   out  [CHANNELS]            one-cycle pulse on delay completion
//   busy_any  out                        any channel running
//
// Optional build macro
//   DELAY_TIMER_RETRIGGER_EN : set while running restarts the channel
//   (ms==0 while running acts as cancel plus one expired pulse).
//   Undefined: set while running is ignored.
//
// Per-channel FSM
//   state  | meaning
//   -------+---------------------------------------------
//   S_IDLE | channel free, waiting for set
//   S_RUN  | counting down rem (ms) / sub (ticks in ms)
// -----------------------------------------------------------------------------
module delay_timer_bank #(
    parameter int CHANNELS     = 4,
    parameter int MS_WIDTH     = 8,
    parameter int TICKS_PER_MS = 2000,
    parameter int TICK_WIDTH   = 14
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHANNELS-1:0]          set,
    input  logic [CHANNELS*MS_WIDTH-1:0] ms,
    input  logic [CHANNELS-1:0]          periodic,
    input  logic [CHANNELS-1:0]          cancel,
    output logic [CHANNELS-1:0]          free,
    output logic [CHANNELS-1:0]          expired,
    output logic                         busy_any
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [TICK_WIDTH-1:0] SUB_RELOAD = TICK_WIDTH'(TICKS_PER_MS - 1);
    localparam logic [MS_WIDTH-1:0]   MS_ONE     = MS_WIDTH'(1);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [0:0]            state_q, state_d;
        logic [MS_WIDTH-1:0]   rem_q, rem_d;
        logic [TICK_WIDTH-1:0] sub_q, sub_d;
        logic [MS_WIDTH-1:0]   ms_lat_q, ms_lat_d;
        logic                  per_lat_q, per_lat_d;
        logic                  exp_q, exp_d;
        logic [MS_WIDTH-1:0]   ms_ch;
        logic                  ms_nonzero;

        assign ms_ch      = ms[i*MS_WIDTH +: MS_WIDTH];
        assign ms_nonzero = (ms_ch != '0);

        always_comb begin
            state_d   = state_q;
            rem_d     = rem_q;
            sub_d     = sub_q;
            ms_lat_d  = ms_lat_q;
            per_lat_d = per_lat_q;
            exp_d     = 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (!cancel[i] && set[i]) begin
                        if (ms_nonzero) begin
                            state_d   = S_RUN;
                            rem_d     = ms_ch;
                            sub_d     = SUB_RELOAD;
                            ms_lat_d  = ms_ch;
                            per_lat_d = periodic[i];
                        end else begin
                            // zero-length delay: report completion without running
                            exp_d = 1'b1;
                        end
                    end
                end
                default: begin
                    if (cancel[i]) begin
                        state_d = S_IDLE;
`ifdef DELAY_TIMER_RETRIGGER_EN
                    end else if (set[i]) begin
                        // retrigger outranks expiry on the same edge
                        if (ms_nonzero) begin
                            rem_d     = ms_ch;
                            sub_d     = SUB_RELOAD;
                            ms_lat_d  = ms_ch;
                            per_lat_d = periodic[i];
                        end else begin
                            state_d = S_IDLE;
                            exp_d   = 1'b1;
                        end
`endif
                    end else if (sub_q != '0) begin
                        sub_d = sub_q - 1'b1;
                    end else if (rem_q > MS_ONE) begin
                        rem_d = rem_q - 1'b1;
                        sub_d = SUB_RELOAD;
                    end else begin
                        exp_d = 1'b1;
                        if (per_lat_q) begin
                            // reload from the latched value so the period never drifts
                            rem_d = ms_lat_q;
                            sub_d = SUB_RELOAD;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= S_IDLE;
                rem_q     <= '0;
                sub_q     <= '0;
                ms_lat_q  <= '0;
                per_lat_q <= 1'b0;
                exp_q     <= 1'b0;
            end else begin
                state_q   <= state_d;
                rem_q     <= rem_d;
                sub_q     <= sub_d;
                ms_lat_q  <= ms_lat_d;
                per_lat_q <= per_lat_d;
                exp_q     <= exp_d;
            end
        end

        assign free[i]    = (state_q == S_IDLE);
        assign expired[i] = exp_q;
    end

    assign busy_any = ~&free;

endmodule

// File: tb/tb_delay_timer_bank.sv
module tb_delay_timer_bank;

    localparam int CH  = 4;
    localparam int MSW = 8;
    localparam int TPM = 4;
    localparam int TW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CH-1:0]     set;
    logic [CH*MSW-1:0] ms;
    logic [CH-1:0]     periodic;
    logic [CH-1:0]     cancel;
    logic [CH-1:0]     free;
    logic [CH-1:0]     expired;
    logic              busy_any;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    delay_timer_bank #(
        .CHANNELS     (CH),
        .MS_WIDTH     (MSW),
        .TICKS_PER_MS (TPM),
        .TICK_WIDTH   (TW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .set      (set),
        .ms       (ms),
        .periodic (periodic),
        .cancel   (cancel),
        .free     (free),
        .expired  (expired),
        .busy_any (busy_any)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        int            bad;
        int            badbusy;
        int            pulses;
        logic [CH-1:0] exp_v;

        rst_n    = 1'b0;
        set      = '0;
        ms       = '0;
        periodic = '0;
        cancel   = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_free", 32'(free), 32'hF);
        chk("rst_expired", 32'(expired), 32'h0);
        chk("rst_busy", 32'(busy_any), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: one-shot ms=3 -> expiry edge E+12
        ms[0 +: MSW] = 8'd3;
        periodic[0]  = 1'b0;
        set[0]       = 1'b1;
        @(negedge clk);
        set = '0;
        chk("t1_free_after_arm", 32'(free[0]), 32'h0);
        chk("t1_busy_after_arm", 32'(busy_any), 32'h1);
        bad = 0;
        for (int k = 1; k < 12; k++) begin
            @(negedge clk);
            if (expired[0] !== 1'b0 || free[0] !== 1'b0) bad++;
        end
        chk("t1_no_early_pulse", 32'(bad), 32'h0);
        @(negedge clk);
        chk("t1_expired", 32'(expired), 32'h1);
        chk("t1_free_with_pulse", 32'(free[0]), 32'h1);
        @(negedge clk);
        chk("t1_pulse_one_cycle", 32'(expired[0]), 32'h0);
        chk("t1_free_stays", 32'(free[0]), 32'h1);

        // 2: periodic ms=2 -> pulse every 8 cycles, then cancel
        ms[MSW +: MSW] = 8'd2;
        periodic[1]    = 1'b1;
        set[1]         = 1'b1;
        @(negedge clk);
        set      = '0;
        periodic = '0;
        chk("t2_free_after_arm", 32'(free[1]), 32'h0);
        bad    = 0;
        pulses = 0;
        for (int n = 1; n <= 44; n++) begin
            @(negedge clk);
            if (expired[1] === 1'b1) pulses++;
            if (expired[1] !== ((n % 8) == 0)) bad++;
            if (free[1] !== 1'b0) bad++;
        end
        chk("t2_pulse_count", 32'(pulses), 32'd5);
        chk("t2_pulse_spacing", 32'(bad), 32'h0);
        cancel[1] = 1'b1;
        @(negedge clk);
        cancel = '0;
        chk("t2_cancel_free", 32'(free[1]), 32'h1);
        chk("t2_cancel_no_pulse", 32'(expired[1]), 32'h0);
        bad = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (expired !== 4'h0 || free !== 4'hF) bad++;
        end
        chk("t2_quiet_after_cancel", 32'(bad), 32'h0);

        // 3: zero-length delay
        ms[2*MSW +: MSW] = 8'd0;
        set[2]           = 1'b1;
        @(negedge clk);
        set = '0;
        chk("t3_expired", 32'(expired), 32'h4);
        chk("t3_free", 32'(free), 32'hF);
        @(negedge clk);
        chk("t3_pulse_once", 32'(expired), 32'h0);
        chk("t3_free_after", 32'(free), 32'hF);

        // 4: all channels ms=1..4 in the same cycle, plus set on running ch3
        ms  = {8'd4, 8'd3, 8'd2, 8'd1};
        set = 4'hF;
        @(negedge clk);
        set = '0;
        chk("t4_all_busy", 32'(free), 32'h0);
        bad     = 0;
        badbusy = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            exp_v = '0;
            for (int i = 0; i < CH; i++) if (n == 4 * (i + 1)) exp_v[i] = 1'b1;
            if (expired !== exp_v) bad++;
            if (busy_any !== (n < 16)) badbusy++;
`ifndef DELAY_TIMER_RETRIGGER_EN
            if (n == 6) begin
                set[3]             = 1'b1;
                ms[3*MSW +: MSW]   = 8'd1;
            end else begin
                set = '0;
            end
`endif
        end
        set = '0;
        chk("t4_pulse_order", 32'(bad), 32'h0);
        chk("t4_busy_fall", 32'(busy_any === 1'b0 && badbusy == 0), 32'h1);

        // 5: asynchronous reset mid-count while a pulse is showing
        ms[0 +: MSW]   = 8'd3;
        ms[MSW +: MSW] = 8'd2;
        periodic       = 4'b0001;
        set            = 4'b0011;
        @(negedge clk);
        set      = '0;
        periodic = '0;
        repeat (8) @(negedge clk);
        chk("t5_pre_reset_pulse", 32'(expired), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_free", 32'(free), 32'hF);
        chk("t5_rst_expired", 32'(expired), 32'h0);
        chk("t5_rst_busy", 32'(busy_any), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (expired !== 4'h0 || free !== 4'hF) bad++;
        end
        chk("t5_quiet_after_reset", 32'(bad), 32'h0);

        // 6: cancel together with set on a running channel -> idle, no pulse
        ms[0 +: MSW] = 8'd3;
        set[0]       = 1'b1;
        @(negedge clk);
        set = '0;
        repeat (3) @(negedge clk);
        set[0]    = 1'b1;
        cancel[0] = 1'b1;
        @(negedge clk);
        set    = '0;
        cancel = '0;
        chk("t6_cancel_set_free", 32'(free[0]), 32'h1);
        bad = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (expired !== 4'h0 || free !== 4'hF) bad++;
        end
        chk("t6_cancel_set_quiet", 32'(bad), 32'h0);

`ifdef DELAY_TIMER_RETRIGGER_EN
        // retrigger 6 cycles after arm -> expiry 12 cycles after the retrigger
        ms[0 +: MSW] = 8'd3;
        set[0]       = 1'b1;
        @(negedge clk);
        set = '0;
        bad = 0;
        for (int n = 1; n <= 22; n++) begin
            @(negedge clk);
            if (expired[0] !== (n == 18)) bad++;
            set[0] = (n == 5);
        end
        set = '0;
        chk("t6_retrigger_timing", 32'(bad), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
